// File: rtl/calc_sequencer.sv
// Keypad front-end for a two-operand calculator: collects digits/operator, sequences one datapath evaluation.
// Optional divide-by-zero trap enabled with CALC_DIVZERO_CHK_EN.
module calc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic [13:0] calc_out,
  output logic [7:0]  A1,
  output logic [7:0]  A0,
  output logic [7:0]  OP,
  output logic [7:0]  B1,
  output logic [7:0]  B0,
  output logic [13:0] result,
  output logic        done,
  output logic        busy,
  output logic [2:0]  state,
  output logic        err
);

  typedef enum logic [2:0] {
    ENT_A  = 3'd0,
    ENT_OP = 3'd1,
    ENT_B  = 3'd2,
    CALC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t      cur, nxt;
  logic [1:0]  a_cnt, b_cnt, a_cnt_nxt, b_cnt_nxt;
  logic [7:0]  a1_nxt, a0_nxt, op_nxt, b1_nxt, b0_nxt;
  logic [13:0] result_nxt;
  logic        done_nxt;
  logic        is_digit, is_oper, is_eq, is_clr;

  assign is_digit = key_valid && (key_code <= 8'h09);
  assign is_oper  = key_valid && (key_code >= 8'h0A) && (key_code <= 8'h0D);
  assign is_eq    = key_valid && (key_code == 8'h0E);
  assign is_clr   = key_valid && (key_code == 8'h0F);

  assign state = cur;
  assign busy  = (cur == CALC);

`ifdef CALC_DIVZERO_CHK_EN
  logic err_q, err_nxt, div_zero;
  assign div_zero = (OP == 8'h0D) && (B1 == 8'h00) && (B0 == 8'h00);
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= ENT_A;
    else      cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    a1_nxt     = A1;
    a0_nxt     = A0;
    op_nxt     = OP;
    b1_nxt     = B1;
    b0_nxt     = B0;
    a_cnt_nxt  = a_cnt;
    b_cnt_nxt  = b_cnt;
    result_nxt = result;
    done_nxt   = 1'b0;
`ifdef CALC_DIVZERO_CHK_EN
    err_nxt    = err_q;
`endif
    // CLR outranks everything, including an in-flight CALC, so no done is produced.
    if (is_clr) begin
      nxt        = ENT_A;
      a1_nxt     = 8'h00;
      a0_nxt     = 8'h00;
      op_nxt     = 8'h00;
      b1_nxt     = 8'h00;
      b0_nxt     = 8'h00;
      a_cnt_nxt  = 2'd0;
      b_cnt_nxt  = 2'd0;
      result_nxt = 14'd0;
`ifdef CALC_DIVZERO_CHK_EN
      err_nxt    = 1'b0;
`endif
    end else begin
      case (cur)
        ENT_A: begin
          if (is_digit && (a_cnt < 2'd2)) begin
            a1_nxt    = A0;
            a0_nxt    = key_code;
            a_cnt_nxt = a_cnt + 2'd1;
          end else if (is_oper && (a_cnt != 2'd0)) begin
            op_nxt = key_code;
            nxt    = ENT_OP;
          end
        end
        ENT_OP: begin
          if (is_oper) begin
            op_nxt = key_code;
          end else if (is_digit) begin
            b1_nxt    = 8'h00;
            b0_nxt    = key_code;
            b_cnt_nxt = 2'd1;
            nxt       = ENT_B;
          end
        end
        ENT_B: begin
          if (is_digit && (b_cnt < 2'd2)) begin
            b1_nxt    = B0;
            b0_nxt    = key_code;
            b_cnt_nxt = b_cnt + 2'd1;
          end else if (is_eq) begin
            nxt = CALC;
          end
        end
        CALC: begin
          // The datapath has had one full cycle on stable operands; capture its answer.
          nxt      = SHOW;
          done_nxt = 1'b1;
`ifdef CALC_DIVZERO_CHK_EN
          if (div_zero) begin
            result_nxt = 14'd0;
            err_nxt    = 1'b1;
          end else begin
            result_nxt = calc_out;
            err_nxt    = 1'b0;
          end
`else
          result_nxt = calc_out;
`endif
        end
        SHOW: begin
          if (is_digit) begin
            a1_nxt    = 8'h00;
            a0_nxt    = key_code;
            op_nxt    = 8'h00;
            b1_nxt    = 8'h00;
            b0_nxt    = 8'h00;
            a_cnt_nxt = 2'd1;
            b_cnt_nxt = 2'd0;
            nxt       = ENT_A;
          end
        end
        default: nxt = ENT_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A1     <= 8'h00;
      A0     <= 8'h00;
      OP     <= 8'h00;
      B1     <= 8'h00;
      B0     <= 8'h00;
      a_cnt  <= 2'd0;
      b_cnt  <= 2'd0;
      result <= 14'd0;
      done   <= 1'b0;
    end else begin
      A1     <= a1_nxt;
      A0     <= a0_nxt;
      OP     <= op_nxt;
      B1     <= b1_nxt;
      B0     <= b0_nxt;
      a_cnt  <= a_cnt_nxt;
      b_cnt  <= b_cnt_nxt;
      result <= result_nxt;
      done   <= done_nxt;
    end
  end

`ifdef CALC_DIVZERO_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key-vector table plus hand sequences for CLR/reset during CALC.
// Expected err/result for divide-by-zero follow CALC_DIVZERO_CHK_EN.
module tb_calc_sequencer;

`ifdef CALC_DIVZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  localparam logic [7:0] K_ADD = 8'h0A;
  localparam logic [7:0] K_SUB = 8'h0B;
  localparam logic [7:0] K_MUL = 8'h0C;
  localparam logic [7:0] K_DIV = 8'h0D;
  localparam logic [7:0] K_EQ  = 8'h0E;
  localparam logic [7:0] K_CLR = 8'h0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [13:0] calc_out;
  logic [7:0]  A1, A0, OP, B1, B0;
  logic [13:0] result;
  logic        done, busy, err;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        kv;
    logic [7:0]  code;
    logic [2:0]  st;
    logic [7:0]  a1, a0, op, b1, b0;
    logic [13:0] res;
    logic        dn, er;
  } vec_t;

  vec_t vecs[$];

  calc_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .calc_out(calc_out), .A1(A1), .A0(A0), .OP(OP), .B1(B1), .B0(B0),
    .result(result), .done(done), .busy(busy), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  // External datapath model; division by zero returns all ones.
  always_comb begin
    int a, b, r;
    a = int'(A1) * 10 + int'(A0);
    b = int'(B1) * 10 + int'(B0);
    case (OP)
      K_ADD:   r = a + b;
      K_SUB:   r = a - b;
      K_MUL:   r = a * b;
      K_DIV:   r = (b == 0) ? 16383 : a / b;
      default: r = 0;
    endcase
    calc_out = r[13:0];
  end

  function automatic vec_t mk(logic kv, logic [7:0] code, logic [2:0] st,
                              logic [7:0] a1, logic [7:0] a0, logic [7:0] op,
                              logic [7:0] b1, logic [7:0] b0, logic [13:0] res,
                              logic dn, logic er);
    vec_t v;
    v.kv = kv; v.code = code; v.st = st;
    v.a1 = a1; v.a0 = a0; v.op = op; v.b1 = b1; v.b0 = b0;
    v.res = res; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic apply_stimulus(input logic kv, input logic [7:0] code);
    @(negedge clk);
    key_valid = kv;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [2:0] st,
                              input logic [7:0] a1, input logic [7:0] a0, input logic [7:0] op,
                              input logic [7:0] b1, input logic [7:0] b0, input logic [13:0] res,
                              input logic dn, input logic er);
    logic bz;
    bz = (st == 3'd3);
    tests++;
    if (state !== st || A1 !== a1 || A0 !== a0 || OP !== op || B1 !== b1 || B0 !== b0 ||
        result !== res || done !== dn || busy !== bz || err !== er) begin
      fails++;
      $display("[TB] FAIL %s: got st=%0d A1=%0d A0=%0d OP=%h B1=%0d B0=%0d res=%0d done=%b busy=%b err=%b; expected st=%0d A1=%0d A0=%0d OP=%h B1=%0d B0=%0d res=%0d done=%b busy=%b err=%b",
               name, state, A1, A0, OP, B1, B0, result, done, busy, err,
               st, a1, a0, op, b1, b0, res, dn, bz, er);
    end
  endtask

  initial begin
    //            kv code   st a1 a0 op     b1 b0 res                  dn er
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 0,    0, 0));
    vecs[0].a0 = 8'd1;
    vecs.push_back(mk(0, 8'h02, 0, 0, 1, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 1, 2, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_ADD, 1, 1, 2, K_ADD, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_EQ,  1, 1, 2, K_ADD, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h03, 2, 1, 2, K_ADD, 0, 3, 0,    0, 0));
    vecs.push_back(mk(1, 8'h04, 2, 1, 2, K_ADD, 3, 4, 0,    0, 0));
    vecs.push_back(mk(1, K_EQ,  3, 1, 2, K_ADD, 3, 4, 0,    0, 0));
    vecs.push_back(mk(0, 8'h00, 4, 1, 2, K_ADD, 3, 4, 46,   1, 0));
    vecs.push_back(mk(0, 8'h00, 4, 1, 2, K_ADD, 3, 4, 46,   0, 0));
    vecs.push_back(mk(1, K_ADD, 4, 1, 2, K_ADD, 3, 4, 46,   0, 0));
    vecs.push_back(mk(1, 8'h07, 0, 0, 7, 8'h00, 0, 0, 46,   0, 0));
    vecs.push_back(mk(1, K_CLR, 0, 0, 0, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h09, 0, 0, 9, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h09, 0, 9, 9, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h09, 0, 9, 9, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_MUL, 1, 9, 9, K_MUL, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h09, 2, 9, 9, K_MUL, 0, 9, 0,    0, 0));
    vecs.push_back(mk(1, 8'h09, 2, 9, 9, K_MUL, 9, 9, 0,    0, 0));
    vecs.push_back(mk(1, 8'h09, 2, 9, 9, K_MUL, 9, 9, 0,    0, 0));
    vecs.push_back(mk(1, K_SUB, 2, 9, 9, K_MUL, 9, 9, 0,    0, 0));
    vecs.push_back(mk(1, K_EQ,  3, 9, 9, K_MUL, 9, 9, 0,    0, 0));
    vecs.push_back(mk(0, 8'h00, 4, 9, 9, K_MUL, 9, 9, 9801, 1, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 5, 8'h00, 0, 0, 9801, 0, 0));
    vecs.push_back(mk(1, K_ADD, 1, 0, 5, K_ADD, 0, 0, 9801, 0, 0));
    vecs.push_back(mk(1, K_SUB, 1, 0, 5, K_SUB, 0, 0, 9801, 0, 0));
    vecs.push_back(mk(1, 8'h02, 2, 0, 5, K_SUB, 0, 2, 9801, 0, 0));
    vecs.push_back(mk(1, K_EQ,  3, 0, 5, K_SUB, 0, 2, 9801, 0, 0));
    vecs.push_back(mk(0, 8'h00, 4, 0, 5, K_SUB, 0, 2, 3,    1, 0));
    vecs.push_back(mk(1, K_CLR, 0, 0, 0, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_ADD, 0, 0, 0, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_EQ,  0, 0, 0, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h08, 0, 0, 8, 8'h00, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_DIV, 1, 0, 8, K_DIV, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, 8'h00, 2, 0, 8, K_DIV, 0, 0, 0,    0, 0));
    vecs.push_back(mk(1, K_EQ,  3, 0, 8, K_DIV, 0, 0, 0,    0, 0));
    vecs.push_back(mk(0, 8'h00, 4, 0, 8, K_DIV, 0, 0, DZ ? 14'd0 : 14'd16383, 1, DZ));
    vecs.push_back(mk(1, 8'h06, 0, 0, 6, 8'h00, 0, 0, DZ ? 14'd0 : 14'd16383, 0, DZ));
    vecs.push_back(mk(1, K_MUL, 1, 0, 6, K_MUL, 0, 0, DZ ? 14'd0 : 14'd16383, 0, DZ));
    vecs.push_back(mk(1, 8'h02, 2, 0, 6, K_MUL, 0, 2, DZ ? 14'd0 : 14'd16383, 0, DZ));
    vecs.push_back(mk(1, K_EQ,  3, 0, 6, K_MUL, 0, 2, DZ ? 14'd0 : 14'd16383, 0, DZ));
    vecs.push_back(mk(0, 8'h00, 4, 0, 6, K_MUL, 0, 2, 12,   1, 0));

    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].kv, vecs[i].code);
      check_output($sformatf("vec%0d", i), vecs[i].st, vecs[i].a1, vecs[i].a0, vecs[i].op,
                   vecs[i].b1, vecs[i].b0, vecs[i].res, vecs[i].dn, vecs[i].er);
    end

    // CLR while in CALC: no done, result cleared
    apply_stimulus(1, 8'h01);
    apply_stimulus(1, K_ADD);
    apply_stimulus(1, 8'h02);
    apply_stimulus(1, K_EQ);
    check_output("clr_pre_calc", 3, 0, 1, K_ADD, 0, 2, 12, 0, 0);
    apply_stimulus(1, K_CLR);
    check_output("clr_in_calc", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    apply_stimulus(0, 8'h00);
    check_output("clr_no_done", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    // Divide by zero, then CLR drops err
    apply_stimulus(1, 8'h08);
    apply_stimulus(1, K_DIV);
    apply_stimulus(1, 8'h00);
    apply_stimulus(1, K_EQ);
    apply_stimulus(0, 8'h00);
    check_output("div0", 4, 0, 8, K_DIV, 0, 0, DZ ? 14'd0 : 14'd16383, 1, DZ);
    apply_stimulus(1, K_CLR);
    check_output("div0_clr", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    // Async reset asserted mid-CALC
    apply_stimulus(1, 8'h03);
    apply_stimulus(1, K_ADD);
    apply_stimulus(1, 8'h04);
    apply_stimulus(1, K_EQ);
    apply_stimulus(0, 8'h00);
    check_output("pre_rst_show", 4, 0, 3, K_ADD, 0, 4, 7, 1, 0);
    apply_stimulus(1, 8'h02);
    apply_stimulus(1, K_SUB);
    apply_stimulus(1, 8'h05);
    apply_stimulus(1, K_EQ);
    check_output("pre_rst_calc", 3, 0, 2, K_SUB, 0, 5, 7, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rst_immediate", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_output("rst_no_done", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(0, 8'h00);
    check_output("rst_release", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (low = reset).
REQ-003 SHALL have port: key_valid  input  1  one-cycle pulse; key_code valid.
REQ-004 SHALL have port: key_code  input  8  0x00-0x09 digit; 0x0A ADD; 0x0B SUB; 0x0C MULT; 0x0D DIV; 0x0E EQ; 0x0F CLR; others ignored.
REQ-005 SHALL have port: calc_out  input  14  datapath result for the current operand/operator registers.
REQ-006 SHALL have ports: A1, A0, OP, B1, B0  output  8 each  registered operand digits and operator code driven to the datapath.
REQ-007 SHALL have port: result  output  14  latched result.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when result updates.
REQ-009 SHALL have port: busy  output  1  high in CALC.
REQ-010 SHALL have port: state  output  3  current FSM state encoding.
REQ-011 SHALL have port: err  output  1  error flag; see Configuration.

Function
REQ-012 SHALL implement states: ENT_A=0, ENT_OP=1, ENT_B=2, CALC=3, SHOW=4.
REQ-013 SHALL accept a key only on a cycle with key_valid=1; all other cycles hold state.
REQ-014 ENT_A digit SHALL shift: A1<=A0, A0<=digit, a_cnt++; digits beyond a_cnt=2 SHALL be ignored.
REQ-015 ENT_A operator key with a_cnt>=1 SHALL load OP and go to ENT_OP; with a_cnt=0 it SHALL be ignored.
REQ-016 ENT_OP operator key SHALL overwrite OP; a digit SHALL load B0, clear B1, set b_cnt=1, and go to ENT_B.
REQ-017 ENT_B digit SHALL shift into B1/B0, capped at 2 digits like A; operator keys SHALL be ignored.
REQ-018 ENT_B EQ SHALL go to CALC; EQ in any other state SHALL be ignored.
REQ-019 CALC SHALL last exactly one cycle, then latch result<=calc_out, pulse done, and enter SHOW.
REQ-020 Latency from EQ acceptance edge to done high SHALL be 2 clock edges.
REQ-021 SHOW digit SHALL clear A1/B1/B0, set OP=0, load A0=digit, set a_cnt=1, and enter ENT_A; result SHALL hold until the next done.
REQ-022 SHOW operator key SHALL be ignored.
REQ-023 CLR in any state, including CALC, SHALL synchronously clear all operand registers, counts, err, and result, and enter ENT_A with no done pulse.
REQ-024 Arithmetic SHALL be performed by the datapath only; this block SHALL NOT modify calc_out (14-bit wrap accepted).
REQ-025 Operand digit registers SHALL only hold values 0-9.

Reset
REQ-026 While rst=0, the block SHALL immediately set state=ENT_A, A1=A0=OP=B1=B0=0, result=0, done=0, busy=0, err=0, and counts=0.
REQ-027 Reset assertion mid-CALC SHALL abort the operation with no done pulse.

Configuration
REQ-028 SHALL use macro CALC_DIVZERO_CHK_EN.
REQ-029 With CALC_DIVZERO_CHK_EN defined, a CALC with OP=DIV and B1=B0=0 SHALL latch result=0, set err=1 (sticky until CLR, reset, or next successful CALC), and still pulse done.
REQ-030 Without CALC_DIVZERO_CHK_EN, err SHALL be tied 0 and calc_out SHALL be latched unconditionally.

Verification
REQ-031 Keys 1,2,ADD,3,4,EQ with calc_out modelled -> A1=1, A0=2, B1=3, B0=4, result=46, done pulses once 2 edges after EQ.
REQ-032 Keys 9,9,9,MULT,9,9,EQ -> third 9 ignored, result=9801, state returns SHOW=4.
REQ-033 Keys 5,ADD,SUB,2,EQ -> OP=0x0B, result=3; EQ before any B digit ignored.
REQ-034 With macro: 8,DIV,0,EQ -> result=0, err=1; then CLR -> err=0, state=0. Without macro: err stays 0.
REQ-035 rst driven low during CALC -> all outputs 0 immediately, no done pulse.
REQ-036 After result shown, key 7 -> A0=7, A1=0, OP=0, state=ENT_A, result unchanged.
